uart_packet_decoder: RTL and testbench
======================================

# uart_packet_decoder

Downstream consumer of the UART receive path. It takes the byte stream produced by the UART receiver (one-cycle `byte_valid` strobe per received byte) and parses framed packets of the form: SOF (0xA5), LEN, LEN payload bytes, CHK. Payload is buffered internally and released to the next stage over a valid/ready stream only after the checksum verifies. Malformed, stalled or overrun frames are discarded and flagged.

## Interface
Parameters:
- `MAX_PAYLOAD`, default 16: maximum payload bytes per packet (1..255); sizes the internal buffer.
- `TIMEOUT_TICKS`, default 640: `baudTick` pulses allowed between consecutive bytes inside a frame before abort (40 bit-times at 16x oversampling).

Ports:
- `clk` in 1: system clock.
- `rstN` in 1: asynchronous, active-low reset.
- `baudTick` in 1: 16x oversample tick shared with the receiver; used only for timeout counting.
- `byte_in` in 8: received byte; sampled only when `byte_valid`=1.
- `byte_valid` in 1: one-cycle strobe, byte complete (driven by the receiver's new_byte_received).
- `out_data` out 8: payload byte at head of output stream.
- `out_valid` out 1: `out_data` valid.
- `out_ready` in 1: downstream accepts `out_data` this cycle.
- `out_last` out 1: current `out_data` is the final payload byte.
- `pkt_len` out 8: LEN of the packet being released; held until next release.
- `busy` out 1: state ≠ IDLE.
- `chk_err`, `len_err`, `timeout_err`, `overrun_err` out 1 each: one-cycle error pulses.

## Operation
- Checksum: 8-bit XOR of LEN and all payload bytes; frame is good when CHK equals it.
- States:
  - IDLE: on `byte_valid` with `byte_in`=0xA5 → LEN. Any other byte is discarded silently.
  - LEN: on byte: value 0 or > `MAX_PAYLOAD` → `len_err`, IDLE. Otherwise store length, init checksum = LEN, write index = 0 → PAYLOAD.
  - PAYLOAD: each byte is written to `buf[wr_idx]`, XORed into checksum, and `wr_idx` is incremented. When the byte at index LEN-1 is stored → CHK.
  - CHK: on byte: match → SEND, with `pkt_len` loaded and `rd_idx`=0. Mismatch → `chk_err`, IDLE.
  - SEND: `out_valid`=1 and `out_data`=`buf[rd_idx]`; `out_last`=1 when `rd_idx`=`pkt_len`-1. When `out_valid`&`out_ready`, `rd_idx`++. When the transfer has `out_last`=1 → IDLE.
- Timeout (LEN, PAYLOAD, CHK only):
  - The counter clears on every accepted byte and on entering LEN.
  - It increments on each `baudTick`.
  - When it reaches `TIMEOUT_TICKS` → `timeout_err`, IDLE, partial frame discarded.
  - `byte_valid` in the same cycle as the limit is reached takes priority: the byte is accepted and the counter is cleared.
- SEND does not accept input. Any `byte_valid` in SEND, including the cycle of the last transfer, drops the byte and pulses `overrun_err`. The state does not change.
- A byte of 0xA5 in LEN/PAYLOAD/CHK is treated as data, not resync.
- Counter width: `$clog2(TIMEOUT_TICKS+1)`. Index widths: `$clog2(MAX_PAYLOAD)`, minimum 1.

## Timing
- All outputs are registered.
- Reset values: `out_valid`=`out_last`=`busy`=0, `out_data`=0, `pkt_len`=0, all error pulses 0. State IDLE, counters 0, buffer contents don't-care.
- `rstN` asserted mid-frame or mid-SEND: immediate return to IDLE; the packet is lost with no error pulse.
- Latency: `out_valid` rises the cycle after the CHK `byte_valid`.
- Error pulses are high for exactly the cycle after the offending `byte_valid` or timeout edge.
- `out_data`/`out_last` are stable while `out_valid`=1 and `out_ready`=0. Back-to-back transfers are allowed every cycle.
- After the last transfer, `out_valid`=0 in the next cycle and the block accepts SOF in that cycle.

## Test plan
- Good frame A5 03 11 22 33 03, `out_ready`=1 → out 11, 22, 33 on consecutive cycles, `out_last` on 33, `pkt_len`=3, no errors.
- Same frame with CHK=04 → `chk_err` pulse once, no `out_valid`, next good frame decoded normally.
- A5 00, then A5 11 with `MAX_PAYLOAD`=16 → two `len_err` pulses. Leading garbage 00 FF 5A before SOF is ignored.
- A5 02 7E then silence for `TIMEOUT_TICKS` baudTicks → `timeout_err`, `busy`=0. Also a byte landing in the same cycle as the limit is accepted with no timeout.
- Good frame with `out_ready` toggling 1/0 → data held during stalls, order preserved. A byte injected during SEND → `overrun_err`, output unaffected.
- `rstN` low in PAYLOAD → all outputs 0. A following good frame decodes correctly.

Source files
------------

// File: rtl/uart_packet_decoder.sv
// Framed packet parser behind the UART receiver: SOF, LEN, payload, XOR CHK.
// Ports: clk/rstN, baudTick, byte_in/byte_valid in; out_* stream, pkt_len, busy, error pulses.
module uart_packet_decoder #(
  parameter int MAX_PAYLOAD   = 16,
  parameter int TIMEOUT_TICKS = 640
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       baudTick,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic [7:0] pkt_len,
  output logic       busy,
  output logic       chk_err,
  output logic       len_err,
  output logic       timeout_err,
  output logic       overrun_err
);

  localparam int IW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam int CW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT_TICKS - 1);
  localparam logic [7:0] MAXL = 8'(MAX_PAYLOAD);
  localparam logic [7:0] SOF = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_PAY, S_CHK, S_SEND
  } state_t;

  state_t state;
  logic [7:0] len_q;
  logic [7:0] chk_q;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic [CW-1:0] tcnt;
  logic [7:0] pbuf [MAX_PAYLOAD];

  logic [IW-1:0] rd_nxt;
  logic [7:0] chk_nxt;
  logic in_frame;
  logic tmo;

  assign rd_nxt = rd_idx + 1'b1;
  assign chk_nxt = chk_q ^ byte_in;
  assign in_frame = (state == S_LEN) || (state == S_PAY) ||
                    (state == S_CHK);
  // A byte arriving on the limit tick wins over the timeout.
  assign tmo = in_frame && !byte_valid && baudTick && (tcnt == TLIM);

  // Payload storage needs no reset; it is always written before read.
  always_ff @(posedge clk) begin
    if (state == S_PAY && byte_valid)
      pbuf[wr_idx] <= byte_in;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state       <= S_IDLE;
      len_q       <= '0;
      chk_q       <= '0;
      wr_idx      <= '0;
      rd_idx      <= '0;
      tcnt        <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      pkt_len     <= '0;
      busy        <= 1'b0;
      chk_err     <= 1'b0;
      len_err     <= 1'b0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      chk_err     <= 1'b0;
      len_err     <= 1'b0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;

      // Outside a frame the counter sits at zero, so LEN starts fresh.
      if (!in_frame)
        tcnt <= '0;
      else if (byte_valid)
        tcnt <= '0;
      else if (baudTick)
        tcnt <= tcnt + 1'b1;

      if (tmo) begin
        state       <= S_IDLE;
        busy        <= 1'b0;
        timeout_err <= 1'b1;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (byte_valid && byte_in == SOF) begin
              state <= S_LEN;
              busy  <= 1'b1;
            end
          end
          S_LEN: begin
            if (byte_valid) begin
              if (byte_in == 8'd0 || byte_in > MAXL) begin
                len_err <= 1'b1;
                state   <= S_IDLE;
                busy    <= 1'b0;
              end else begin
                len_q  <= byte_in;
                chk_q  <= byte_in;
                wr_idx <= '0;
                state  <= S_PAY;
              end
            end
          end
          S_PAY: begin
            if (byte_valid) begin
              chk_q  <= chk_nxt;
              wr_idx <= wr_idx + 1'b1;
              if (8'(wr_idx) == len_q - 8'd1)
                state <= S_CHK;
            end
          end
          S_CHK: begin
            if (byte_valid) begin
              if (byte_in == chk_q) begin
                state     <= S_SEND;
                pkt_len   <= len_q;
                rd_idx    <= '0;
                out_valid <= 1'b1;
                out_data  <= pbuf[0];
                out_last  <= (len_q == 8'd1);
              end else begin
                chk_err <= 1'b1;
                state   <= S_IDLE;
                busy    <= 1'b0;
              end
            end
          end
          S_SEND: begin
            if (byte_valid)
              overrun_err <= 1'b1;
            if (out_ready) begin
              if (out_last) begin
                state     <= S_IDLE;
                busy      <= 1'b0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
              end else begin
                rd_idx   <= rd_nxt;
                out_data <= pbuf[rd_nxt];
                out_last <= (8'(rd_nxt) == pkt_len - 8'd1);
              end
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_packet_decoder.sv
// Directed bench for uart_packet_decoder.
// Drives bytes on negedges, checks registered outputs on the following negedge.
module tb_uart_packet_decoder;

  logic       clk = 1'b0;
  logic       rstN;
  logic       baudTick;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic [7:0] pkt_len;
  logic       busy;
  logic       chk_err;
  logic       len_err;
  logic       timeout_err;
  logic       overrun_err;

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_packet_decoder #(
    .MAX_PAYLOAD(16),
    .TIMEOUT_TICKS(640)
  ) dut (
    .clk(clk),
    .rstN(rstN),
    .baudTick(baudTick),
    .byte_in(byte_in),
    .byte_valid(byte_valid),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last),
    .pkt_len(pkt_len),
    .busy(busy),
    .chk_err(chk_err),
    .len_err(len_err),
    .timeout_err(timeout_err),
    .overrun_err(overrun_err)
  );

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in = b;
    byte_valid = 1'b1;
    step();
    byte_valid = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      baudTick = 1'b1;
      step();
      baudTick = 1'b0;
    end
  endtask

  initial begin
    rstN = 1'b0;
    baudTick = 1'b0;
    byte_in = 8'h00;
    byte_valid = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    check("rst_valid", out_valid, 8'h0);
    check("rst_data", out_data, 8'h0);
    check("rst_len", pkt_len, 8'h0);
    check("rst_busy", busy, 8'h0);
    check("rst_errs", {chk_err, len_err, timeout_err, overrun_err}, 8'h0);
    rstN = 1'b1;
    step();

    // good frame, ready held high
    send_byte(8'hA5);
    check("sof_busy", busy, 8'h1);
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h03);
    check("g1_valid0", out_valid, 8'h1);
    check("g1_data0", out_data, 8'h11);
    check("g1_last0", out_last, 8'h0);
    check("g1_len", pkt_len, 8'h03);
    step();
    check("g1_data1", out_data, 8'h22);
    step();
    check("g1_data2", out_data, 8'h33);
    check("g1_last2", out_last, 8'h1);
    step();
    check("g1_done_valid", out_valid, 8'h0);
    check("g1_done_busy", busy, 8'h0);
    check("g1_errs", {chk_err, len_err, timeout_err, overrun_err}, 8'h0);

    // bad checksum
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h04);
    check("bad_chk_err", chk_err, 8'h1);
    check("bad_chk_valid", out_valid, 8'h0);
    check("bad_chk_busy", busy, 8'h0);
    step();
    check("bad_chk_pulse", chk_err, 8'h0);

    // next good frame; 0xA5 inside payload is data
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'hA5);
    send_byte(8'h5A);
    send_byte(8'hFD);
    check("g2_valid", out_valid, 8'h1);
    check("g2_data0", out_data, 8'hA5);
    check("g2_len", pkt_len, 8'h02);
    step();
    check("g2_data1", out_data, 8'h5A);
    check("g2_last", out_last, 8'h1);
    step();
    check("g2_done", out_valid, 8'h0);

    // garbage and length errors
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    check("garbage_busy", busy, 8'h0);
    check("garbage_errs", {chk_err, len_err, timeout_err, overrun_err}, 8'h0);
    send_byte(8'hA5);
    send_byte(8'h00);
    check("len0_err", len_err, 8'h1);
    check("len0_busy", busy, 8'h0);
    send_byte(8'hA5);
    check("len_pulse", len_err, 8'h0);
    send_byte(8'h11);
    check("len17_err", len_err, 8'h1);
    step();
    check("len17_pulse", len_err, 8'h0);

    // timeout
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h7E);
    ticks(639);
    check("tmo_pre_busy", busy, 8'h1);
    check("tmo_pre_err", timeout_err, 8'h0);
    ticks(1);
    check("tmo_err", timeout_err, 8'h1);
    check("tmo_busy", busy, 8'h0);
    step();
    check("tmo_pulse", timeout_err, 8'h0);

    // byte on the limit tick is accepted
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h7E);
    ticks(639);
    baudTick = 1'b1;
    send_byte(8'h7F);
    baudTick = 1'b0;
    check("edge_no_tmo", timeout_err, 8'h0);
    check("edge_busy", busy, 8'h1);
    send_byte(8'h03);
    check("edge_valid", out_valid, 8'h1);
    check("edge_data0", out_data, 8'h7E);
    step();
    check("edge_data1", out_data, 8'h7F);
    check("edge_last", out_last, 8'h1);
    step();
    check("edge_done", out_valid, 8'h0);

    // backpressure and overrun
    out_ready = 1'b0;
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'hC1);
    send_byte(8'hC2);
    send_byte(8'hC3);
    send_byte(8'hC3);
    check("bp_valid", out_valid, 8'h1);
    check("bp_data0", out_data, 8'hC1);
    step();
    check("bp_hold0", out_data, 8'hC1);
    check("bp_hold0_last", out_last, 8'h0);
    out_ready = 1'b1;
    step();
    check("bp_data1", out_data, 8'hC2);
    out_ready = 1'b0;
    step();
    check("bp_hold1", out_data, 8'hC2);
    send_byte(8'h55);
    check("ovr_err", overrun_err, 8'h1);
    check("ovr_data", out_data, 8'hC2);
    check("ovr_valid", out_valid, 8'h1);
    out_ready = 1'b1;
    step();
    check("bp_data2", out_data, 8'hC3);
    check("bp_last", out_last, 8'h1);
    check("ovr_pulse", overrun_err, 8'h0);
    send_byte(8'h66);
    check("ovr_last_err", overrun_err, 8'h1);
    check("ovr_last_valid", out_valid, 8'h0);
    check("ovr_last_busy", busy, 8'h0);

    // reset in payload
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h11);
    check("mid_busy", busy, 8'h1);
    #1 rstN = 1'b0;
    #1;
    check("arst_busy", busy, 8'h0);
    check("arst_valid", out_valid, 8'h0);
    check("arst_data", out_data, 8'h0);
    check("arst_len", pkt_len, 8'h0);
    step();
    rstN = 1'b1;
    step();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h99);
    send_byte(8'h98);
    check("post_valid", out_valid, 8'h1);
    check("post_data", out_data, 8'h99);
    check("post_last", out_last, 8'h1);
    check("post_len", pkt_len, 8'h01);
    step();
    check("post_done", out_valid, 8'h0);
    check("post_errs", {chk_err, len_err, timeout_err, overrun_err}, 8'h0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
